// File: rtl/rr_dec_arbiter_pkg.sv
// Shared types and helpers for the round-robin decoder arbiter.
// Optional feature macro: ARB_LOCK_EN (adds a lock input that suppresses the hold-time timeout).
package arb_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Search upward from ptr+1, wrapping; the first set request wins.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [IDX_W-1:0] ptr);
        pick_t            p;
        logic [IDX_W-1:0] k;
        p = '0;
        for (int i = 1; i <= NREQ; i++) begin
            k = ptr + IDX_W'(i);
            if (!p.found && req[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

endpackage : arb_pkg

// File: rtl/rr_dec_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// Optional feature macro: ARB_LOCK_EN (adds the lock signal).
interface rr_dec_arbiter_if;
    import arb_pkg::*;

    logic [NREQ-1:0]  req;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_v;
    logic [NREQ-1:0]  gnt;
    logic [CNT_W-1:0] hold_cnt;
`ifdef ARB_LOCK_EN
    logic             lock;

    modport master (output req, output lock, input gnt_idx, input gnt_v, input gnt, input hold_cnt);
    modport slave  (input req, input lock, output gnt_idx, output gnt_v, output gnt, output hold_cnt);
`else
    modport master (output req, input gnt_idx, input gnt_v, input gnt, input hold_cnt);
    modport slave  (input req, output gnt_idx, output gnt_v, output gnt, output hold_cnt);
`endif

endinterface : rr_dec_arbiter_if

// File: rtl/rr_dec_arbiter_gnt_dec.sv
// 2-to-4 decoder with enable; turns the registered grant index/valid into a one-hot grant.
module gnt_dec
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [NREQ-1:0]  gnt_o
);

    assign gnt_o = en_i ? (NREQ'(1) << idx_i) : '0;

endmodule : gnt_dec

// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter for 4 requesters with a bounded hold time per owner.
// Optional feature macro: ARB_LOCK_EN (lock input keeps the owner past MAX_HOLD).
module rr_dec_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    rr_dec_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [NREQ-1:0]  owner_mask;
    logic [NREQ-1:0]  others;
    logic             owner_req;
    logic             at_max;
    logic             lock_act;
    pick_t            pick_free;
    pick_t            pick_next;

    assign owner_mask = NREQ'(1) << gnt_idx_q;
    assign others     = bus.req & ~owner_mask;
    assign owner_req  = bus.req[gnt_idx_q];
    assign at_max     = (hold_cnt_q == MAX_CNT);
    assign pick_free  = rr_pick(bus.req, ptr_q);
    assign pick_next  = rr_pick(others, gnt_idx_q);

`ifdef ARB_LOCK_EN
    assign lock_act = bus.lock;
`else
    assign lock_act = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its default first, so no path can infer a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_idx_d  = gnt_idx_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_free.found) begin
                    state_d    = ARB_GRANT;
                    gnt_idx_d  = pick_free.idx;
                    ptr_d      = pick_free.idx;
                    hold_cnt_d = CNT_W'(1);
                end
            end

            ARB_GRANT: begin
                if (!owner_req) begin
                    if (pick_next.found) begin
                        gnt_idx_d  = pick_next.idx;
                        ptr_d      = pick_next.idx;
                        hold_cnt_d = CNT_W'(1);
                    end else begin
                        state_d    = ARB_IDLE;
                        hold_cnt_d = '0;
                    end
                end else if (at_max && !lock_act) begin
                    // Timeout: hand over if anyone else waits, otherwise restart the hold window.
                    if (pick_next.found) begin
                        gnt_idx_d = pick_next.idx;
                        ptr_d     = pick_next.idx;
                    end
                    hold_cnt_d = CNT_W'(1);
                end else if (at_max) begin
                    hold_cnt_d = MAX_CNT;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d    = ARB_IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values.
        if (rst) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= IDX_W'(3);
            gnt_idx_q  <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign bus.gnt_idx  = gnt_idx_q;
    assign bus.gnt_v    = (state_q == ARB_GRANT);
    assign bus.hold_cnt = hold_cnt_q;

    gnt_dec u_gnt_dec (
        .idx_i (gnt_idx_q),
        .en_i  (state_q == ARB_GRANT),
        .gnt_o (bus.gnt)
    );

endmodule : rr_dec_arbiter

// File: tb/tb_rr_dec_arbiter.sv
// Self-checking bench for rr_dec_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_rr_dec_arbiter;

    localparam int MAX_HOLD = 8;

    logic clk;
    logic rst;

    rr_dec_arbiter_if bus ();

    rr_dec_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner -1 means idle.
    int m_owner;
    int m_last;
    int m_hold;
    int m_lock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [3:0] r, input int from);
        for (int i = 1; i <= 4; i++) begin
            if (r[(from + i) % 4]) return (from + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_hold  = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        logic [3:0] oth;
        int p;
        if (m_owner < 0) begin
            p = first_from(r, m_last);
            if (p >= 0) begin
                m_owner = p; m_last = p; m_hold = 1;
            end
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
            p = first_from(oth, m_owner);
            if (!r[m_owner]) begin
                if (p >= 0) begin
                    m_owner = p; m_last = p; m_hold = 1;
                end else begin
                    m_owner = -1; m_hold = 0;
                end
            end else if (m_hold == MAX_HOLD && m_lock == 0) begin
                if (p >= 0) begin
                    m_owner = p; m_last = p;
                end
                m_hold = 1;
            end else if (m_hold < MAX_HOLD) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".gnt_v"}, 32'(bus.gnt_v), (m_owner >= 0) ? 32'd1 : 32'd0);
        check({tag, ".gnt"}, 32'(bus.gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check({tag, ".hold"}, 32'(bus.hold_cnt), 32'(m_hold));
        if (m_owner >= 0) check({tag, ".idx"}, 32'(bus.gnt_idx), 32'(m_owner));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(bus.req);
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_reset_between_edges(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check({tag, ".v"}, 32'(bus.gnt_v), 32'd0);
        check({tag, ".gnt"}, 32'(bus.gnt), 32'd0);
        check({tag, ".hold"}, 32'(bus.hold_cnt), 32'd0);
        #1;
        rst = 1'b0;
    endtask

    int order[$];
    int last_idx;

    initial begin
        model_reset();
        m_lock = 0;
        rst = 1'b1;
        bus.req = 4'b1111;
`ifdef ARB_LOCK_EN
        bus.lock = 1'b0;
`endif

        // Reset with all requests asserted.
        repeat (2) @(posedge clk);
        #1;
        check("rst.v", 32'(bus.gnt_v), 32'd0);
        check("rst.gnt", 32'(bus.gnt), 32'd0);
        check("rst.hold", 32'(bus.hold_cnt), 32'd0);
        check("rst.idx", 32'(bus.gnt_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("first");
        check("first.idx0", 32'(bus.gnt_idx), 32'd0);
        check("first.gnt0001", 32'(bus.gnt), 32'b0001);

        // Fair rotation: each owner drops its request once it has held for 3 cycles.
        order.push_back(int'(bus.gnt_idx));
        last_idx = int'(bus.gnt_idx);
        for (int i = 0; i < 16; i++) begin
            bus.req = 4'b1111;
            if (m_hold == 3) bus.req[m_owner[1:0]] = 1'b0;
            step("rot");
            check("rot.nogap", 32'(bus.gnt_v), 32'd1);
            if (int'(bus.gnt_idx) != last_idx) begin
                last_idx = int'(bus.gnt_idx);
                order.push_back(last_idx);
            end
        end
        check("rot.count", (order.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < order.size()) check("rot.order", 32'(order[k]), 32'(k % 4));
        end

        // Timeout between two requesters.
        bus.req = 4'b0011;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step("tmo");
            check("tmo.idx", 32'(bus.gnt_idx), 32'((i / 8) % 2));
            check("tmo.hold", 32'(bus.hold_cnt), 32'((i % 8) + 1));
        end

        // Lone owner keeps the grant and hold_cnt wraps 1..MAX_HOLD.
        bus.req = 4'b0000;
        step("lone.idle");
        bus.req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            step("lone");
            check("lone.idx", 32'(bus.gnt_idx), 32'd2);
            check("lone.hold", 32'(bus.hold_cnt), 32'((i % MAX_HOLD) + 1));
        end

        // Release to idle, then re-grant.
        bus.req = 4'b1000;
        step("rel.g3");
        check("rel.idx3", 32'(bus.gnt_idx), 32'd3);
        bus.req = 4'b0000;
        step("rel.idle");
        check("rel.v0", 32'(bus.gnt_v), 32'd0);
        check("rel.gnt0", 32'(bus.gnt), 32'd0);
        bus.req = 4'b0001;
        step("rel.g0");
        check("rel.gnt0001", 32'(bus.gnt), 32'b0001);

        // Asynchronous reset while requester 1 holds the grant.
        bus.req = 4'b0010;
        do_reset();
        step("mid.g1");
        check("mid.gnt0010", 32'(bus.gnt), 32'b0010);
        pulse_reset_between_edges("mid.rst");
        step("mid.after");

`ifdef ARB_LOCK_EN
        // Lock keeps owner 0 past MAX_HOLD until it drops its request.
        bus.req  = 4'b0011;
        bus.lock = 1'b1;
        m_lock   = 1;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step("lock");
            check("lock.idx", 32'(bus.gnt_idx), 32'd0);
        end
        bus.req = 4'b0010;
        step("lock.drop");
        check("lock.idx1", 32'(bus.gnt_idx), 32'd1);
        bus.lock = 1'b0;
        m_lock   = 0;
`endif

        // Random traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) bus.req = 4'($urandom_range(0, 15));
`ifdef ARB_LOCK_EN
            if ($urandom_range(0, 7) == 0) begin
                bus.lock = ~bus.lock;
                m_lock   = int'(bus.lock);
            end
`endif
            step("rnd");
            if ($urandom_range(0, 99) == 0) pulse_reset_between_edges("rnd.rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rr_dec_arbiter

// File: doc/rr_dec_arbiter.md
Name: rr_dec_arbiter

Overview:
- Round-robin arbiter that shares one 2-to-4 decoder-selected resource among 4 requesters.
- Produces a registered 2-bit grant index and a grant-valid strobe, which drive the decoder's select and enable inputs directly.
- Also produces the decoded one-hot grant vector.
- Enforces a maximum hold time so that no requester starves the others.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant while another requester is pending; legal range 2..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; one clock, reset is asynchronous and active-high.
- req  input  4  request vector; bit k high = requester k wants the resource.
- gnt_idx  output  2  index of the current owner; feeds decoder select.
- gnt_v  output  1  grant valid; feeds decoder enable.
- gnt  output  4  one-hot grant, equal to decode(gnt_idx) when gnt_v is high, else 4'b0000.
- hold_cnt  output  8  cycles the current owner has held the grant; 0 when idle.

Behaviour:
- Reset values (asynchronous, immediate):
  - gnt_idx=2'b00, gnt_v=0, gnt=4'b0000, hold_cnt=0.
  - State=IDLE, last-owner pointer ptr=2'd3, so the first search starts at requester 0.
- All outputs are registered. gnt is decoded from the registered gnt_idx/gnt_v and carries no extra latency.
- Round-robin pick: search req starting at (ptr+1) mod 4 and wrapping upward. The first set bit wins.
- State IDLE:
  - If req != 0 at edge N, take the pick. At N+1: gnt_v=1, gnt_idx=pick, ptr=pick, hold_cnt=1, state=GRANT.
  - Otherwise remain in IDLE.
  - Latency from request to grant is 1 cycle.
- State GRANT (owner o=gnt_idx), evaluated each edge in this priority order:
  1. req[o]=0 (release):
     - If any other req bit is set, hand over to the pick in the same edge: gnt_idx=pick, hold_cnt=1, with no idle cycle.
     - Otherwise go to IDLE: gnt_v=0, hold_cnt=0.
  2. req[o]=1, hold_cnt==MAX_HOLD, and another bit is set (timeout): force handover to the pick, which excludes o; hold_cnt=1.
  3. req[o]=1, hold_cnt==MAX_HOLD, and no other bit is set: keep the owner; hold_cnt reloads to 1.
  4. Otherwise keep the owner; hold_cnt increments.
- hold_cnt never exceeds MAX_HOLD.
- ptr updates on every new grant and never on idle.
- Simultaneous requests: resolved purely by round-robin order from ptr+1.
- A requester that deasserts req in the same cycle it would be picked is not granted.
- Glitch-free handover: gnt is one-hot or zero at every cycle. At most one bit is ever set.
- Reset mid-grant: outputs clear asynchronously, and ptr returns to 3.

Optional Feature:
- Macro: ARB_LOCK_EN.
- With the macro defined:
  - Adds input lock (1 bit).
  - While lock=1 and gnt_v=1, the timeout rule (item 2) is suppressed. The owner keeps the grant until it drops req.
  - hold_cnt saturates at MAX_HOLD.
  - lock has no effect in IDLE.
- Without the macro: there is no lock port, and the timeout is always enforced.

Decomposition:
- Package arb_pkg:
  - NREQ=4, IDX_W=2, CNT_W=8.
  - Enumerated state type arb_state_t {ARB_IDLE, ARB_GRANT}.
  - Function rr_pick(req, ptr) returning the index and a found flag.
- One sub-module, gnt_dec:
  - A 2-to-4 decoder with enable, producing gnt from gnt_idx/gnt_v.
  - It is instantiated once and is the only combinational child.

Test Plan:
- Reset and idle:
  - Assert rst with req=4'b1111. Required: gnt_v=0, gnt=0000, hold_cnt=0.
  - Release rst. Required: one cycle later gnt_idx=0, gnt=0001.
- Fair rotation:
  - Hold req=1111, and have each owner drop its bit for one cycle after 3 cycles of grant. Required: grant order 0,1,2,3,0 with no idle gaps.
- Timeout:
  - Use MAX_HOLD=8. Hold req=0011 continuously. Required: owner 0 holds 8 cycles (hold_cnt 1..8), then gnt_idx=1 for 8 cycles, then back to 0.
- Lone owner:
  - Hold req=0100 for 20 cycles. Required: gnt_idx=2 throughout, and hold_cnt cycles 1..8 repeatedly.
- Release to idle:
  - Grant to 3, then set req=0000. Required: next cycle gnt_v=0, gnt=0000.
  - Then set req=0001. Required: the grant goes to 0 one cycle later.
- Async reset mid-grant and lock:
  - Pulse rst between edges while gnt=0010. Required: outputs clear immediately.
  - With ARB_LOCK_EN, lock=1, req=0011. Required: owner 0 keeps the grant past 8 cycles until req[0] drops.
